// File: rtl/parity_unit.sv
// N-channel parity generator/checker with sticky error flags and saturating error counters.
// Two-stage pipeline (capture, evaluate), one transaction per channel per cycle, never stalls.
module parity_unit #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2,
  parameter bit ODD      = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_check,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_par,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS-1:0]       out_par,
  output logic [CHANNELS-1:0]       out_err,
  output logic [CHANNELS-1:0]       err_sticky,
  output logic [CHANNELS*CNT_W-1:0] err_count,
  input  logic [CHANNELS-1:0]       clr
);

  typedef struct packed {
    logic             check;
    logic             par;
    logic [WIDTH-1:0] data;
  } s1_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    s1_t              s1_q;
    logic             s1_valid;
    logic             p;
    logic             word_bad;
    logic             vld_q;
    logic             par_q;
    logic             err_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_q     <= '0;
      end else begin
        s1_valid <= in_valid[c];
        if (in_valid[c]) begin
          s1_q <= '{check: in_check[c], par: in_par[c], data: in_data[c*WIDTH +: WIDTH]};
        end
      end
    end

    assign p = ^s1_q.data;
    // Bad when the ones-parity of data plus received bit differs from the selected sense.
    assign word_bad = p ^ s1_q.par ^ ODD;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        par_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        vld_q <= s1_valid;
        err_q <= s1_valid & s1_q.check & word_bad;
        if (s1_valid) begin
          par_q <= p ^ ODD;
        end
      end
    end

    // A clear coinciding with an error restarts the count at one so the error is kept.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else if (err_q) begin
        sticky_q <= 1'b1;
        if (clr[c]) begin
          cnt_q <= CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (clr[c]) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end
    end

    assign out_valid[c]                = vld_q;
    assign out_par[c]                  = par_q;
    assign out_err[c]                  = err_q;
    assign err_sticky[c]               = sticky_q;
    assign err_count[c*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_parity_unit.sv
// Self-checking bench for parity_unit: directed vector table, hand sequences, and a randomized
// sweep over several parameter sets against a cycle-level reference model.
module tb_parity_unit;

  localparam int NI = 5;

  function automatic int iw(input int k);
    case (k) 0: return 12; 1: return 12; 2: return 1; 3: return 36; default: return 36; endcase
  endfunction
  function automatic int ich(input int k);
    case (k) 0: return 2; 1: return 2; 2: return 8; 3: return 8; default: return 1; endcase
  endfunction
  function automatic int iodd(input int k);
    case (k) 0: return 1; 1: return 0; 2: return 1; 3: return 0; default: return 1; endcase
  endfunction
  function automatic int icw(input int k);
    case (k) 0: return 8; 1: return 2; 2: return 3; 3: return 4; default: return 16; endcase
  endfunction

  logic clk;
  logic rst_n;

  logic [NI-1:0][7:0]   t_valid, t_check, t_par, t_clr;
  logic [NI-1:0][287:0] t_data;
  logic [NI-1:0][7:0]   r_valid, r_par, r_err, r_sticky;
  logic [NI-1:0][127:0] r_cnt;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W  = iw(g);
    localparam int C  = ich(g);
    localparam int O  = iodd(g);
    localparam int CW = icw(g);
    logic [C-1:0]    ov, op, oe, os;
    logic [C*CW-1:0] oc;

    parity_unit #(.WIDTH(W), .CHANNELS(C), .ODD(O != 0), .CNT_W(CW)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (t_valid[g][C-1:0]),
      .in_check   (t_check[g][C-1:0]),
      .in_data    (t_data[g][C*W-1:0]),
      .in_par     (t_par[g][C-1:0]),
      .out_valid  (ov),
      .out_par    (op),
      .out_err    (oe),
      .err_sticky (os),
      .err_count  (oc),
      .clr        (t_clr[g][C-1:0])
    );

    assign r_valid[g]  = 8'(ov);
    assign r_par[g]    = 8'(op);
    assign r_err[g]    = 8'(oe);
    assign r_sticky[g] = 8'(os);
    assign r_cnt[g]    = 128'(oc);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one captured transaction per channel and the visible result/status.
  bit m_s1v [NI][8];
  bit m_chk [NI][8];
  int m_ones[NI][8];
  bit m_par [NI][8];
  bit e_vld [NI][8];
  bit e_par [NI][8];
  bit e_err [NI][8];
  bit e_stk [NI][8];
  int e_cnt [NI][8];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 8; c++) begin
        m_s1v[k][c] = 0; m_chk[k][c] = 0; m_ones[k][c] = 0; m_par[k][c] = 0;
        e_vld[k][c] = 0; e_par[k][c] = 0; e_err[k][c] = 0; e_stk[k][c] = 0; e_cnt[k][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      int w    = iw(k);
      int odd  = iodd(k);
      int cmax = (1 << icw(k)) - 1;
      for (int c = 0; c < ich(k); c++) begin
        if (e_err[k][c]) begin
          e_stk[k][c] = 1;
          e_cnt[k][c] = t_clr[k][c] ? 1 : ((e_cnt[k][c] < cmax) ? e_cnt[k][c] + 1 : cmax);
        end else if (t_clr[k][c]) begin
          e_stk[k][c] = 0;
          e_cnt[k][c] = 0;
        end
        e_vld[k][c] = m_s1v[k][c];
        e_err[k][c] = m_s1v[k][c] && m_chk[k][c] && (((m_ones[k][c] + int'(m_par[k][c])) % 2) != odd);
        if (m_s1v[k][c]) e_par[k][c] = ((m_ones[k][c] + odd) % 2) == 1;
        m_s1v[k][c] = t_valid[k][c];
        if (t_valid[k][c]) begin
          int ones = 0;
          for (int i = 0; i < w; i++) ones += int'(t_data[k][c*w + i]);
          m_ones[k][c] = ones;
          m_chk[k][c]  = t_check[k][c];
          m_par[k][c]  = t_par[k][c];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      logic [7:0]   ev, ep, ee, es;
      logic [127:0] ec;
      int           cw = icw(k);
      ev = '0; ep = '0; ee = '0; es = '0; ec = '0;
      for (int c = 0; c < ich(k); c++) begin
        ev[c] = e_vld[k][c]; ep[c] = e_par[k][c]; ee[c] = e_err[k][c]; es[c] = e_stk[k][c];
        for (int i = 0; i < cw; i++) ec[c*cw + i] = e_cnt[k][c][i];
      end
      chk($sformatf("k%0d out_valid", k), 128'(r_valid[k]), 128'(ev));
      chk($sformatf("k%0d out_par", k), 128'(r_par[k]), 128'(ep));
      chk($sformatf("k%0d out_err", k), 128'(r_err[k]), 128'(ee));
      chk($sformatf("k%0d err_sticky", k), 128'(r_sticky[k]), 128'(es));
      chk($sformatf("k%0d err_count", k), r_cnt[k], ec);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    t_valid = '0; t_check = '0; t_par = '0; t_clr = '0; t_data = '0;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 9; i++) t_data[k][i*32 +: 32] = $urandom();
      t_valid[k] = 8'($urandom()) | 8'($urandom());
      t_check[k] = 8'($urandom());
      t_par[k]   = 8'($urandom());
      for (int c = 0; c < 8; c++) t_clr[k][c] = ($urandom_range(0, 31) == 0);
    end
  endtask

  task automatic drive_one(input int k, input bit chk_mode, input logic [11:0] d, input bit p);
    idle();
    t_valid[k][0]     = 1'b1;
    t_check[k][0]     = chk_mode;
    t_data[k][11:0]   = d;
    t_par[k][0]       = p;
  endtask

  typedef struct {
    string       name;
    int          k;
    bit          chk_mode;
    logic [11:0] data;
    bit          par;
    bit          exp_par;
    bit          exp_err;
  } vec_t;

  vec_t tab[9];

  initial begin
    int pulses0, pulses1;
    int vld_seen;

    tab[0] = '{"odd gen 7777",   0, 0, 12'o7777, 0, 1, 0};
    tab[1] = '{"odd gen 0001",   0, 0, 12'o0001, 0, 0, 0};
    tab[2] = '{"odd chk good",   0, 1, 12'o0000, 1, 1, 0};
    tab[3] = '{"odd chk bad",    0, 1, 12'o0000, 0, 1, 1};
    tab[4] = '{"odd chk 0003",   0, 1, 12'o0003, 1, 1, 0};
    tab[5] = '{"even gen 7777",  1, 0, 12'o7777, 1, 0, 0};
    tab[6] = '{"even gen 0001",  1, 0, 12'o0001, 0, 1, 0};
    tab[7] = '{"even chk good",  1, 1, 12'o0000, 0, 0, 0};
    tab[8] = '{"even chk bad",   1, 1, 12'o0000, 1, 0, 1};

    model_reset();
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset holds everything at zero regardless of input activity.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
    end
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst k%0d out_valid", k), 128'(r_valid[k]), '0);
      chk($sformatf("rst k%0d out_par", k), 128'(r_par[k]), '0);
      chk($sformatf("rst k%0d out_err", k), 128'(r_err[k]), '0);
      chk($sformatf("rst k%0d err_sticky", k), 128'(r_sticky[k]), '0);
      chk($sformatf("rst k%0d err_count", k), r_cnt[k], '0);
    end
    idle();
    rst_n = 1'b1;
    tick();

    foreach (tab[i]) begin
      drive_one(tab[i].k, tab[i].chk_mode, tab[i].data, tab[i].par);
      tick();
      idle();
      tick();
      chk({tab[i].name, " out_valid"}, 128'(r_valid[tab[i].k][0]), 128'(1'b1));
      chk({tab[i].name, " out_par"}, 128'(r_par[tab[i].k][0]), 128'(tab[i].exp_par));
      chk({tab[i].name, " out_err"}, 128'(r_err[tab[i].k][0]), 128'(tab[i].exp_err));
      tick();
      chk({tab[i].name, " pulse ends"}, 128'(r_err[tab[i].k][0]), '0);
    end
    chk("single err sticky", 128'(r_sticky[0][0]), 128'(1'b1));
    chk("single err count", 128'(r_cnt[0][7:0]), 128'(8'd1));

    // Streaming on channel 0 of instance 0, alternating bad parity, channel 1 idle.
    t_clr[0] = 8'h03;
    tick();
    idle();
    chk("stream pre-clear count", r_cnt[0], '0);
    pulses0 = 0;
    pulses1 = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      if (i < 8) begin
        t_valid[0][0] = 1'b1;
        t_check[0][0] = 1'b1;
        t_par[0][0]   = i[0];
      end
      tick();
      pulses0 += int'(r_err[0][0]);
      pulses1 += int'(r_err[0][1]);
    end
    chk("stream ch0 pulses", 128'(pulses0), 128'(4));
    chk("stream ch1 pulses", 128'(pulses1), 128'(0));
    chk("stream ch0 count", 128'(r_cnt[0][7:0]), 128'(8'd4));
    chk("stream ch1 count", 128'(r_cnt[0][15:8]), 128'(8'd0));

    // Saturation and clear on the 2-bit counter instance (even sense: zero data with par 1 is bad).
    t_clr[1] = 8'h03;
    tick();
    idle();
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i < 5) begin
        t_valid[1][0] = 1'b1; t_check[1][0] = 1'b1; t_par[1][0] = 1'b1;
      end
      tick();
    end
    chk("sat count", 128'(r_cnt[1][1:0]), 128'(2'd3));
    chk("sat sticky", 128'(r_sticky[1][0]), 128'(1'b1));
    drive_one(1, 1, 12'o0000, 1);
    tick();
    idle();
    tick();
    chk("sixth err visible", 128'(r_err[1][0]), 128'(1'b1));
    t_clr[1][0] = 1'b1;
    tick();
    idle();
    chk("clr+err count", 128'(r_cnt[1][1:0]), 128'(2'd1));
    chk("clr+err sticky", 128'(r_sticky[1][0]), 128'(1'b1));
    t_clr[1][0] = 1'b1;
    tick();
    idle();
    chk("clr count", 128'(r_cnt[1][1:0]), '0);
    chk("clr sticky", 128'(r_sticky[1][0]), '0);

    // Reset while a transaction sits in the first stage: it must never emerge.
    drive_one(0, 0, 12'o7777, 0);
    @(posedge clk);
    model_edge();
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    idle();
    tick();
    rst_n = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vld_seen += int'(r_valid[0][0]);
    end
    chk("mid-reset no out_valid", 128'(vld_seen), '0);

    for (int n = 0; n < 2500; n++) begin
      rand_inputs();
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
